// File: rtl/tx_ffe_serializer.sv
// LSB-first serializer with a 2-tap FFE (main cursor plus post-cursor de-emphasis) that drives a signed DAC code.
// Optional macro TX_PRBS_EN adds a prbs_en input that sends PRBS7 through the same FFE while the block is idle.
module tx_ffe_serializer #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CODE_W-2:0]        c0,
    input  logic [CODE_W-2:0]        c1,
`ifdef TX_PRBS_EN
    input  logic                     prbs_en,
`endif
    output logic signed [CODE_W-1:0] dac_code,
    output logic                     tx_active
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic signed [CODE_W:0] CODE_MAX = {2'b00, {(CODE_W-1){1'b1}}};
    localparam logic signed [CODE_W:0] CODE_MIN = -CODE_MAX;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CODE_W-2:0]   c0_q, c1_q;
    logic                prev_bit_q, prev_valid_q;

    logic                accept, last, prbs_run, emit, tx_bit;
    logic [CODE_W-2:0]   w0, w1;
    logic signed [CODE_W:0] main_t, post_t, sum;
    logic signed [CODE_W-1:0] code_sat;

`ifdef TX_PRBS_EN
    logic [6:0] lfsr_q;
    assign prbs_run = prbs_en && (state_q == IDLE);
    // PRBS uses the live weights since there is no accept to latch them.
    assign tx_bit   = prbs_run ? lfsr_q[6] : shreg_q[0];
    assign w0       = prbs_run ? c0 : c0_q;
    assign w1       = prbs_run ? c1 : c1_q;
`else
    assign prbs_run = 1'b0;
    assign tx_bit   = shreg_q[0];
    assign w0       = c0_q;
    assign w1       = c1_q;
`endif

    assign last     = (cnt_q == CNT_W'(WIDTH - 1));
    assign in_ready = !rst && !prbs_run && ((state_q == IDLE) || last);
    assign accept   = in_valid && in_ready;
    assign emit     = (state_q == SHIFT) || prbs_run;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last)   state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        main_t = tx_bit ? $signed({2'b00, w0}) : -$signed({2'b00, w0});
        post_t = '0;
        if (prev_valid_q)
            post_t = prev_bit_q ? -$signed({2'b00, w1}) : $signed({2'b00, w1});
        sum = main_t + post_t;
        if (sum > CODE_MAX)
            code_sat = CODE_MAX[CODE_W-1:0];
        else if (sum < CODE_MIN)
            code_sat = CODE_MIN[CODE_W-1:0];
        else
            code_sat = sum[CODE_W-1:0];
    end

    // NOTE: non-blocking updates; a later assignment in this block (accept) overrides the shift/count step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            c0_q         <= '0;
            c1_q         <= '0;
            prev_bit_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            dac_code     <= '0;
            tx_active    <= 1'b0;
`ifdef TX_PRBS_EN
            lfsr_q       <= 7'h7F;
`endif
        end else begin
            state_q <= state_d;
            if (emit) begin
                dac_code     <= code_sat;
                tx_active    <= 1'b1;
                prev_bit_q   <= tx_bit;
                prev_valid_q <= 1'b1;
            end else begin
                dac_code     <= '0;
                tx_active    <= 1'b0;
                prev_valid_q <= 1'b0;
            end
            if (state_q == SHIFT) begin
                shreg_q <= shreg_q >> 1;
                cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
            end
            if (accept) begin
                shreg_q <= in_data;
                c0_q    <= c0;
                c1_q    <= c1;
                cnt_q   <= '0;
            end
`ifdef TX_PRBS_EN
            if (prbs_run)
                lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
        end
    end

endmodule
